// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the sequential divider.
//   DIV_WIDTH   : default operand/result width for seq_divider
//   div_state_t : divider control states (IDLE, RUN, DONE)
package alu_pkg;

   localparam int DIV_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } div_state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake bundle for seq_divider.
//   start, dividend, divisor : request side (driven by master)
//   busy, done               : status (driven by slave)
//   quotient, remainder      : registered results (driven by slave)
//   div_by_zero              : registered divide-by-zero flag (driven by slave)
interface seq_divider_if #(
   parameter int WIDTH = alu_pkg::DIV_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/ripple_subtractor.sv
// Ripple subtractor built from a chain of full-adder cells: a + ~b + 1.
//   a, b   : N-bit operands
//   diff   : N-bit difference a - b
//   borrow : high when a < b (inverted carry-out)
module ripple_subtractor #(
   parameter int N = 9
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         borrow
);

   logic [N:0]   c;
   logic [N-1:0] nb;

   assign nb   = ~b;
   assign c[0] = 1'b1;

   for (genvar i = 0; i < N; i++) begin : g_fa
      assign diff[i]  = a[i] ^ nb[i] ^ c[i];
      assign c[i+1]   = (a[i] & nb[i]) | (a[i] & c[i]) | (nb[i] & c[i]);
   end

   assign borrow = ~c[N];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : seq_divider_if slave (start/operands in, busy/done/results out)
// Optional macro SEQ_DIVIDER_SIGNED_EN: two's-complement operands; magnitudes
// are divided by the same core and signs are fixed up when results register.
module seq_divider
   import alu_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic          clk,
   input  logic          reset,
   seq_divider_if.slave  bus
);

   localparam int CW = $clog2(WIDTH + 1);

   div_state_t       state;
   logic [WIDTH:0]   r;
   logic [WIDTH:0]   r_sh;
   logic [WIDTH:0]   diff;
   logic [WIDTH:0]   r_next;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] d;
   logic [CW-1:0]    count;
   logic             borrow;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;
   logic             unused_bits;

   // Remainder stays below the divisor, so r[WIDTH] is always 0 between
   // steps; the borrow output duplicates the trial MSB in this range.
   assign unused_bits = ^{r[WIDTH], borrow};

   assign r_sh = {r[WIDTH-1:0], q[WIDTH-1]};

   ripple_subtractor #(.N(WIDTH + 1)) u_sub (
      .a      (r_sh),
      .b      ({1'b0, d}),
      .diff   (diff),
      .borrow (borrow)
   );

   always_comb begin
      r_next = diff[WIDTH] ? r_sh : diff;
      q_next = {q[WIDTH-2:0], ~diff[WIDTH]};
   end

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic neg_q;
   logic neg_r;

   assign op_a  = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
   assign op_b  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
   assign q_fix = neg_q ? -q_next : q_next;
   assign r_fix = neg_r ? -r_next[WIDTH-1:0] : r_next[WIDTH-1:0];
`else
   assign op_a  = bus.dividend;
   assign op_b  = bus.divisor;
   assign q_fix = q_next;
   assign r_fix = r_next[WIDTH-1:0];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.quotient    <= '0;
         bus.remainder   <= '0;
         bus.div_by_zero <= 1'b0;
         r               <= '0;
         q               <= '0;
         d               <= '0;
         count           <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         neg_q           <= 1'b0;
         neg_r           <= 1'b0;
`endif
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               state <= IDLE;
               if (bus.start) begin
                  r     <= '0;
                  q     <= op_a;
                  d     <= op_b;
                  count <= CW'(WIDTH);
`ifdef SEQ_DIVIDER_SIGNED_EN
                  neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                  neg_r <= bus.dividend[WIDTH-1];
`endif
                  if (bus.divisor == '0) begin
                     state           <= DONE;
                     bus.done        <= 1'b1;
                     bus.quotient    <= '1;
                     bus.remainder   <= bus.dividend;
                     bus.div_by_zero <= 1'b1;
                  end else begin
                     state    <= RUN;
                     bus.busy <= 1'b1;
                  end
               end
            end
            RUN: begin
               r     <= r_next;
               q     <= q_next;
               count <= count - CW'(1);
               // Results register on the final step so done and the new
               // results appear together; count reaches 0 as DONE is entered.
               if (count == CW'(1)) begin
                  state           <= DONE;
                  bus.busy        <= 1'b0;
                  bus.done        <= 1'b1;
                  bus.quotient    <= q_fix;
                  bus.remainder   <= r_fix;
                  bus.div_by_zero <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

   localparam int W = 8;

   logic clk = 1'b0;
   logic reset;

   seq_divider_if #(.WIDTH(W)) bus ();

   seq_divider #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      int           cyc;
      string        name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;
   logic prev_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   // Monitor: pops the scoreboard whenever the DUT signals completion.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset && bus.done) begin
         chk("done single-cycle", {31'd0, prev_done}, 32'd0);
         if (sb.size() == 0) begin
            chk("unexpected done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk({e.name, " quotient"},    {24'd0, bus.quotient},  {24'd0, e.q});
            chk({e.name, " remainder"},   {24'd0, bus.remainder}, {24'd0, e.r});
            chk({e.name, " div_by_zero"}, {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
            chk({e.name, " done cycle"},  cyc, e.cyc);
         end
      end
      prev_done = reset ? 1'b0 : bus.done;
   end

   task automatic issue(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] qe, input logic [W-1:0] re, input logic dz,
                        input bit expect_result);
      @(posedge clk); #1;
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      if (expect_result)
         sb.push_back('{qe, re, dz, cyc + 1 + ((b == '0) ? 0 : W), name});
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (b != '0) chk({name, " busy after accept"}, {31'd0, bus.busy}, 32'd1);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      chk({name, " pending results"}, sb.size(), 32'd0);
      sb.delete();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " busy"},        {31'd0, bus.busy},        32'd0);
      chk({tag, " done"},        {31'd0, bus.done},        32'd0);
      chk({tag, " quotient"},    {24'd0, bus.quotient},    32'd0);
      chk({tag, " remainder"},   {24'd0, bus.remainder},   32'd0);
      chk({tag, " div_by_zero"}, {31'd0, bus.div_by_zero}, 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      reset        = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      reset = 1'b0;

      issue("100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b1);
      drain("100/7");
      chk("100/7 held quotient", {24'd0, bus.quotient}, 32'd14);
      chk("100/7 busy idle",     {31'd0, bus.busy},     32'd0);

      issue("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b1);
      drain("255/1");
      issue("3/10", 8'd3, 8'd10, 8'd0, 8'd3, 1'b0, 1'b1);
      drain("3/10");

      issue("5/0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1'b1);
      drain("5/0");
      issue("9/3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 1'b1);
      drain("9/3");

      // Second start at cycle 4 must be ignored while busy.
`ifdef SEQ_DIVIDER_SIGNED_EN
      issue("200/13", 8'd200, 8'd13, 8'hFC, 8'hFC, 1'b0, 1'b1);
`else
      issue("200/13", 8'd200, 8'd13, 8'd15, 8'd5, 1'b0, 1'b1);
`endif
      repeat (3) @(posedge clk);
      #1;
      bus.start    = 1'b1;
      bus.dividend = 8'd50;
      bus.divisor  = 8'd5;
      @(posedge clk); #1;
      bus.start = 1'b0;
      drain("200/13");

      // Reset at cycle 5 aborts without a done pulse.
      issue("77/4 aborted", 8'd77, 8'd4, 8'd0, 8'd0, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk_zero("mid-run reset");
      repeat (W + 4) @(posedge clk);
      #1;
      chk_zero("after abort");
      issue("77/4", 8'd77, 8'd4, 8'd19, 8'd1, 1'b0, 1'b1);
      drain("77/4");

      // Back-to-back with start held high.
      @(posedge clk); #1;
      k            = cyc;
      bus.start    = 1'b1;
      bus.dividend = 8'd20;
      bus.divisor  = 8'd6;
      sb.push_back('{8'd3, 8'd2, 1'b0, k + 1 + W, "b2b 20/6"});
      sb.push_back('{8'd4, 8'd1, 1'b0, k + 1 + W + W + 1, "b2b 9/2"});
      @(posedge clk); #1;
      bus.dividend = 8'd9;
      bus.divisor  = 8'd2;
      repeat (W + 1) @(posedge clk);
      #1;
      bus.start = 1'b0;
      drain("back-to-back");

`ifdef SEQ_DIVIDER_SIGNED_EN
      issue("-7/2",    8'hF9, 8'd2,  8'hFD, 8'hFF, 1'b0, 1'b1);
      drain("-7/2");
      issue("-128/-1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1);
      drain("-128/-1");
      issue("7/-2",    8'd7,  8'hFE, 8'hFD, 8'h01, 1'b0, 1'b1);
      drain("7/-2");
      issue("-8/0",    8'hF8, 8'd0,  8'hFF, 8'hF8, 1'b1, 1'b1);
      drain("-8/0");
`else
      issue("255/255", 8'd255, 8'd255, 8'd1, 8'd0,   1'b0, 1'b1);
      drain("255/255");
      issue("254/255", 8'd254, 8'd255, 8'd0, 8'd254, 1'b0, 1'b1);
      drain("254/255");
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
